// File: rtl/cascade_modn_pkg.sv
// -----------------------------------------------------------------------------
// cascade_modn_pkg
// Shared definitions for the cascaded mod-N counter:
//   - digit_w_f / count_w_f : width derivation used by the parameter lists
//   - clamp_digit           : folds an out-of-range digit down to RADIX-1
//   - dir_e                 : counting direction encoding
// -----------------------------------------------------------------------------
package cascade_modn_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Bits needed to hold one digit of modulus radix.
   function automatic int unsigned digit_w_f(input int unsigned radix);
      return $clog2(radix);
   endfunction

   // Width of the packed multi-digit count.
   function automatic int unsigned count_w_f(input int unsigned radix,
                                             input int unsigned stages);
      return stages * digit_w_f(radix);
   endfunction

   // A digit field can encode values >= radix when radix is not a power
   // of two; such values are stored as the largest legal digit.
   function automatic int unsigned clamp_digit(input int unsigned d,
                                               input int unsigned radix);
      return (d >= radix) ? (radix - 32'd1) : d;
   endfunction

endpackage : cascade_modn_pkg

// File: rtl/modn_digit_stage.sv
// -----------------------------------------------------------------------------
// modn_digit_stage
// One mod-RADIX digit register. It steps up or down when step is high and
// wraps at the boundary. A load stores load_digit clamped to RADIX-1.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   step       in   advance this digit on the current edge
//   up_dn      in   1 = increment, 0 = decrement
//   load       in   parallel load strobe (overrides step)
//   load_digit in   digit value to load
//   digit      out  registered digit value
//   at_max     out  digit == RADIX-1
//   at_min     out  digit == 0
// -----------------------------------------------------------------------------
module modn_digit_stage
   import cascade_modn_pkg::*;
#(
   parameter int unsigned RADIX   = 32'd4,
   parameter int unsigned DIGIT_W = digit_w_f(RADIX)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               step,
   input  logic               up_dn,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_digit,
   output logic [DIGIT_W-1:0] digit,
   output logic               at_max,
   output logic               at_min
);

   localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(RADIX - 32'd1);

   logic [DIGIT_W-1:0] r_digit;
   logic [DIGIT_W-1:0] w_next;
   logic [DIGIT_W-1:0] w_load_clamped;

   assign w_load_clamped = DIGIT_W'(clamp_digit(32'(load_digit), RADIX));

   // Next value for one step in the current direction, wrapping at the ends.
   always_comb begin
      w_next = r_digit;
      if (up_dn == DIR_UP) begin
         if (r_digit == MAX_DIGIT) begin
            w_next = '0;
         end else begin
            w_next = r_digit + DIGIT_W'(1);
         end
      end else begin
         if (r_digit == '0) begin
            w_next = MAX_DIGIT;
         end else begin
            w_next = r_digit - DIGIT_W'(1);
         end
      end
   end

   // Digit register: reset > load > step > hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_digit <= '0;
      end else if (load) begin
         r_digit <= w_load_clamped;
      end else if (step) begin
         r_digit <= w_next;
      end else begin
         r_digit <= r_digit;
      end
   end

   assign digit  = r_digit;
   assign at_max = (r_digit == MAX_DIGIT);
   assign at_min = (r_digit == '0);

endmodule : modn_digit_stage

// File: rtl/cascade_modn_counter.sv
// -----------------------------------------------------------------------------
// cascade_modn_counter
// Fully synchronous cascade of NUM_STAGES mod-RADIX digits. Carries and
// borrows are clock enables into each digit, never derived clocks.
// Ports:
//   clk         in   rising-edge clock for all state
//   reset       in   synchronous active-low reset
//   en          in   count enable
//   up_dn       in   1 = increment, 0 = decrement
//   load        in   parallel load strobe (priority over en)
//   load_val    in   packed digits to load, digit 0 in the LSBs
//   count       out  registered packed count, digit 0 least significant
//   stage_carry out  bit i high when digit i wraps on this edge
//   tc          out  count is at the terminal value for the direction
// Build option:
//   CASCADE_MODN_COUNTER_SATURATE_EN - hold at full scale / zero instead of
//   wrapping; tc stays high while held, stage_carry stays low.
// -----------------------------------------------------------------------------
module cascade_modn_counter
   import cascade_modn_pkg::*;
#(
   parameter  int unsigned RADIX      = 32'd4,
   parameter  int unsigned NUM_STAGES = 32'd3,
   localparam int unsigned DIGIT_W    = digit_w_f(RADIX),
   localparam int unsigned COUNT_W    = count_w_f(RADIX, NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [COUNT_W-1:0]    load_val,
   output logic [COUNT_W-1:0]    count,
   output logic [NUM_STAGES-1:0] stage_carry,
   output logic                  tc
);

   logic [NUM_STAGES-1:0] w_at_max;
   logic [NUM_STAGES-1:0] w_at_min;
   logic [NUM_STAGES-1:0] w_edge;   // digit sits at its wrap point for the direction
   logic [NUM_STAGES-1:0] w_step;
   logic                  w_active;
   logic                  w_full;
   logic                  w_step_en;

   assign w_active = en & ~load & reset;
   assign w_edge   = (up_dn == DIR_UP) ? w_at_max : w_at_min;
   assign w_full   = &w_edge;

`ifdef CASCADE_MODN_COUNTER_SATURATE_EN
   // At the terminal value no digit moves, so nothing wraps.
   assign w_step_en = w_active & ~w_full;
`else
   assign w_step_en = w_active;
`endif

   // Step chain: digit i moves when all lower digits sit at their wrap point.
   always_comb begin
      logic chain_v;
      chain_v = w_step_en;
      w_step  = '0;
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
         w_step[i] = chain_v;
         chain_v   = chain_v & w_edge[i];
      end
   end

   assign stage_carry = w_step & w_edge;
   assign tc          = w_active & w_full;

   genvar g;
   generate
      for (g = 0; g < int'(NUM_STAGES); g++) begin : g_digit
         modn_digit_stage #(
            .RADIX   (RADIX),
            .DIGIT_W (DIGIT_W)
         ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .step       (w_step[g]),
            .up_dn      (up_dn),
            .load       (load),
            .load_digit (load_val[g*DIGIT_W +: DIGIT_W]),
            .digit      (count[g*DIGIT_W +: DIGIT_W]),
            .at_max     (w_at_max[g]),
            .at_min     (w_at_min[g])
         );
      end
   endgenerate

endmodule : cascade_modn_counter

// File: tb/tb_cascade_modn_counter.sv
// -----------------------------------------------------------------------------
// tb_cascade_modn_counter
// Two instances (RADIX=4 x3 digits, RADIX=10 x2 digits) share controls.
// A numeric model (count as an integer modulo RADIX**NUM_STAGES) predicts
// outputs; expectations go through a queue to an independent monitor.
// -----------------------------------------------------------------------------
module tb_cascade_modn_counter;

   localparam int unsigned RA = 4;
   localparam int unsigned NA = 3;
   localparam int unsigned DA = 2;
   localparam int unsigned WA = 6;
   localparam int unsigned RB = 10;
   localparam int unsigned NB = 2;
   localparam int unsigned DB = 4;
   localparam int unsigned WB = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          up_dn;
   logic          load;
   logic [WA-1:0] lva;
   logic [WB-1:0] lvb;
   logic [WA-1:0] count_a;
   logic [NA-1:0] carry_a;
   logic          tc_a;
   logic [WB-1:0] count_b;
   logic [NB-1:0] carry_b;
   logic          tc_b;

   always #5 clk = ~clk;

   cascade_modn_counter #(.RADIX(RA), .NUM_STAGES(NA)) u_dut_a (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(lva), .count(count_a), .stage_carry(carry_a), .tc(tc_a));

   cascade_modn_counter #(.RADIX(RB), .NUM_STAGES(NB)) u_dut_b (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(lvb), .count(count_b), .stage_carry(carry_b), .tc(tc_b));

   typedef struct {
      logic [WA-1:0] cnt_a;
      logic [NA-1:0] car_a;
      logic          tc_a;
      logic [WB-1:0] cnt_b;
      logic [NB-1:0] car_b;
      logic          tc_b;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned v_a = 0;
   int unsigned v_b = 0;

   function automatic int unsigned ipow(input int unsigned b, input int unsigned e);
      int unsigned r = 1;
      for (int k = 0; k < int'(e); k++) r = r * b;
      return r;
   endfunction

   // Counter as an integer in [0, radix**nst): step is +/-1 modulo that range.
   function automatic void model(input int unsigned radix, input int unsigned nst,
                                 input int unsigned dw, input logic [31:0] lv,
                                 input logic rst_n, input logic ld, input logic en_i,
                                 input logic up_i, input int unsigned v,
                                 output int unsigned v_next, output logic [31:0] carry,
                                 output logic tc_o);
      int unsigned m = ipow(radix, nst);
      int unsigned d;
      int unsigned p;
      logic full;
      logic sat_hold;
      carry  = 32'd0;
      tc_o   = 1'b0;
      v_next = v;
      if (!rst_n) begin
         v_next = 0;
      end else if (ld) begin
         v_next = 0;
         for (int i = 0; i < int'(nst); i++) begin
            d = (lv >> (i * dw)) & ((32'd1 << dw) - 32'd1);
            if (d >= radix) d = radix - 1;
            v_next = v_next + d * ipow(radix, i);
         end
      end else if (en_i) begin
         full = up_i ? (v == m - 1) : (v == 0);
         tc_o = full;
`ifdef CASCADE_MODN_COUNTER_SATURATE_EN
         sat_hold = full;
`else
         sat_hold = 1'b0;
`endif
         if (!sat_hold) begin
            for (int i = 0; i < int'(nst); i++) begin
               p = ipow(radix, i + 1);
               carry[i] = up_i ? ((v % p) == p - 1) : ((v % p) == 0);
            end
            v_next = up_i ? (v + 1) % m : (v + m - 1) % m;
         end
      end
   endfunction

   function automatic logic [31:0] pack(input int unsigned radix, input int unsigned nst,
                                        input int unsigned dw, input int unsigned v);
      logic [31:0] r = 32'd0;
      for (int i = 0; i < int'(nst); i++)
         r = r | (((v / ipow(radix, i)) % radix) << (i * dw));
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs and queue the predicted response.
   task automatic drive(input logic rst_n, input logic ld, input logic [WA-1:0] la,
                        input logic [WB-1:0] lb, input logic e, input logic u);
      exp_t        x;
      int unsigned na;
      int unsigned nb;
      logic [31:0] ca;
      logic [31:0] cb;
      logic        ta;
      logic        tb;
      @(posedge clk);
      #1;
      reset = rst_n; load = ld; lva = la; lvb = lb; en = e; up_dn = u;
      model(RA, NA, DA, 32'(la), rst_n, ld, e, u, v_a, na, ca, ta);
      model(RB, NB, DB, 32'(lb), rst_n, ld, e, u, v_b, nb, cb, tb);
      x.car_a = ca[NA-1:0];
      x.tc_a  = ta;
      x.cnt_a = WA'(pack(RA, NA, DA, na));
      x.car_b = cb[NB-1:0];
      x.tc_b  = tb;
      x.cnt_b = WB'(pack(RB, NB, DB, nb));
      v_a = na;
      v_b = nb;
      sb_q.push_back(x);
   endtask

   // Monitor: combinational outputs before the edge, count after it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("tc_a",    32'(tc_a),    32'(e.tc_a));
            check("carry_a", 32'(carry_a), 32'(e.car_a));
            check("tc_b",    32'(tc_b),    32'(e.tc_b));
            check("carry_b", 32'(carry_b), 32'(e.car_b));
            @(posedge clk);
            #2;
            check("count_a", 32'(count_a), 32'(e.cnt_a));
            check("count_b", 32'(count_b), 32'(e.cnt_b));
         end
      end
   end

   initial begin
      reset = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0;
      lva = '0; lvb = '0;
      // Reset held with en high, the second cycle also strobing load.
      drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 6'd33, 8'h45, 1'b1, 1'b1);
      // Full walk 0..63 and back to 0.
      for (int i = 0; i < 65; i++) drive(1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1);
      // Load 47 (digits 2,3,3) then step to 48.
      drive(1'b1, 1'b1, 6'b10_11_11, 8'h00, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1);
      // Down from zero: full borrow, then 63, 62, ...
      drive(1'b1, 1'b1, 6'd0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0);
      // Radix-10 instance: digits {9,12} clamp to 99, then wrap to 00.
      drive(1'b1, 1'b1, 6'd5, 8'h9C, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1);
      // Reset mid-count wins over a simultaneous load.
      drive(1'b1, 1'b1, 6'b01_01_01, 8'h21, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 6'h3F, 8'h99, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1);
      // Full scale: held by saturate build, wraps otherwise; then reverse.
      drive(1'b1, 1'b1, 6'h3F, 8'h99, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0);
      // Enable low holds.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1);
      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
               WA'($urandom), WB'($urandom), $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)));
      end
      for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
      repeat (2) @(posedge clk);
      #5;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_cascade_modn_counter
